sweep_peak_finder: RTL and testbench

Receive-side companion to the triangle-wave sweep generator: watches the sweep value and direction flag it drives, together with a detector signal, and reports the detector maximum and the sweep position at which it occurred for every completed half-sweep. Sits between the sweep generator and the lock-acquisition logic. After a configurable number of consecutive half-sweeps whose peak clears a threshold, it raises `found` so control logic can stop the sweep and engage the servo at `peak_pos`.

---
 rtl/sweep_peak_finder.sv | 171 +++++++++++++++++
 tb/tb_sweep_peak_finder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sweep_peak_finder.sv
// Peak detector for a triangle-wave sweep: reports the detector maximum and its sweep
// position for every completed half-sweep, and flags lock after consecutive hits.
module sweep_peak_finder #(
    parameter int SWEEP_SIZE = 16,
    parameter int DET_SIZE   = 16,
    parameter int NCONFIRM   = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         on,
    input  logic signed [SWEEP_SIZE-1:0] sweep_in,
    input  logic                         sweep_state,
    input  logic signed [DET_SIZE-1:0]   det_in,
    input  logic signed [DET_SIZE-1:0]   threshold,
    output logic signed [DET_SIZE-1:0]   peak_val,
    output logic signed [SWEEP_SIZE-1:0] peak_pos,
    output logic                         peak_dir,
    output logic                         peak_hit,
    output logic                         peak_valid,
    output logic                         found,
    output logic [15:0]                  half_count
);

    localparam logic [3:0] CONF_MAX = 4'(NCONFIRM);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        TRACK = 2'd2
    } state_t;

    // Input stage
    logic signed [SWEEP_SIZE-1:0] sw_q;
    logic signed [DET_SIZE-1:0]   det_q;
    logic                         st_q;
    logic                         st_qq;
    logic                         rev;

    state_t                       state_reg, state_next;
    logic signed [DET_SIZE-1:0]   run_max_reg, run_max_next;
    logic signed [SWEEP_SIZE-1:0] run_pos_reg, run_pos_next;
    logic [3:0]                   conf_cnt_reg, conf_cnt_next;
    logic                         found_reg, found_next;
    logic [15:0]                  half_count_reg, half_count_next;
    logic signed [DET_SIZE-1:0]   peak_val_reg, peak_val_next;
    logic signed [SWEEP_SIZE-1:0] peak_pos_reg, peak_pos_next;
    logic                         peak_dir_reg, peak_dir_next;
    logic                         peak_hit_reg, peak_hit_next;
    logic                         peak_valid_reg, peak_valid_next;

    logic                         hit;
    logic [3:0]                   conf_inc;

    assign rev      = (st_q != st_qq);
    assign hit      = (run_max_reg >= threshold);
    assign conf_inc = (conf_cnt_reg < CONF_MAX) ? conf_cnt_reg + 4'd1 : conf_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_q  <= '0;
            det_q <= '0;
            st_q  <= 1'b0;
            st_qq <= 1'b0;
        end else begin
            sw_q  <= sweep_in;
            det_q <= det_in;
            st_q  <= sweep_state;
            st_qq <= st_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            run_max_reg    <= '0;
            run_pos_reg    <= '0;
            conf_cnt_reg   <= '0;
            found_reg      <= 1'b0;
            half_count_reg <= '0;
            peak_val_reg   <= '0;
            peak_pos_reg   <= '0;
            peak_dir_reg   <= 1'b0;
            peak_hit_reg   <= 1'b0;
            peak_valid_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            run_max_reg    <= run_max_next;
            run_pos_reg    <= run_pos_next;
            conf_cnt_reg   <= conf_cnt_next;
            found_reg      <= found_next;
            half_count_reg <= half_count_next;
            peak_val_reg   <= peak_val_next;
            peak_pos_reg   <= peak_pos_next;
            peak_dir_reg   <= peak_dir_next;
            peak_hit_reg   <= peak_hit_next;
            peak_valid_reg <= peak_valid_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        run_max_next    = run_max_reg;
        run_pos_next    = run_pos_reg;
        conf_cnt_next   = conf_cnt_reg;
        found_next      = found_reg;
        half_count_next = half_count_reg;
        peak_val_next   = peak_val_reg;
        peak_pos_next   = peak_pos_reg;
        peak_dir_next   = peak_dir_reg;
        peak_hit_next   = peak_hit_reg;
        peak_valid_next = 1'b0;

        // Dropping the enable wins over any pending reversal: the half-sweep is discarded.
        if (!on) begin
            state_next      = IDLE;
            run_max_next    = '0;
            run_pos_next    = '0;
            conf_cnt_next   = '0;
            found_next      = 1'b0;
            half_count_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next = ARM;
                end
                ARM: begin
                    if (rev) begin
                        state_next   = TRACK;
                        run_max_next = det_q;
                        run_pos_next = sw_q;
                    end
                end
                TRACK: begin
                    if (rev) begin
                        peak_val_next   = run_max_reg;
                        peak_pos_next   = run_pos_reg;
                        peak_dir_next   = st_qq;
                        peak_hit_next   = hit;
                        peak_valid_next = 1'b1;
                        half_count_next = half_count_reg + 16'd1;
                        if (hit) begin
                            conf_cnt_next = conf_inc;
                            found_next    = (conf_inc == CONF_MAX);
                        end else begin
                            conf_cnt_next = '0;
                            found_next    = 1'b0;
                        end
                        // Reversal sample seeds the new half-sweep unconditionally.
                        run_max_next = det_q;
                        run_pos_next = sw_q;
                    end else if (det_q > run_max_reg) begin
                        run_max_next = det_q;
                        run_pos_next = sw_q;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign peak_val   = peak_val_reg;
    assign peak_pos   = peak_pos_reg;
    assign peak_dir   = peak_dir_reg;
    assign peak_hit   = peak_hit_reg;
    assign peak_valid = peak_valid_reg;
    assign found      = found_reg;
    assign half_count = half_count_reg;

endmodule

// File: tb/tb_sweep_peak_finder.sv
// Directed bench for sweep_peak_finder: drives sweep ramps one sample per clock and
// checks reports, confirm logic, abort and reset behaviour against hand-derived values.
module tb_sweep_peak_finder;

    logic               clk = 1'b0;
    logic               rst;
    logic               on;
    logic signed [15:0] sweep_in;
    logic               sweep_state;
    logic signed [15:0] det_in;
    logic signed [15:0] threshold;
    logic signed [15:0] peak_val;
    logic signed [15:0] peak_pos;
    logic               peak_dir;
    logic               peak_hit;
    logic               peak_valid;
    logic               found;
    logic [15:0]        half_count;

    int checks   = 0;
    int failures = 0;
    int pv_count = 0;

    // Snapshot of the most recent report, taken when peak_valid is seen
    logic signed [15:0] s_val;
    logic signed [15:0] s_pos;
    logic               s_dir;
    logic               s_hit;
    logic               s_found;
    logic [15:0]        s_hc;

    sweep_peak_finder #(
        .SWEEP_SIZE(16),
        .DET_SIZE  (16),
        .NCONFIRM  (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .on         (on),
        .sweep_in   (sweep_in),
        .sweep_state(sweep_state),
        .det_in     (det_in),
        .threshold  (threshold),
        .peak_val   (peak_val),
        .peak_pos   (peak_pos),
        .peak_dir   (peak_dir),
        .peak_hit   (peak_hit),
        .peak_valid (peak_valid),
        .found      (found),
        .half_count (half_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sw, input logic st, input int det);
        sweep_in    = 16'(sw);
        sweep_state = st;
        det_in      = 16'(det);
        @(posedge clk);
        #1;
        if (peak_valid === 1'b1) begin
            pv_count++;
            s_val   = peak_val;
            s_pos   = peak_pos;
            s_dir   = peak_dir;
            s_hit   = peak_hit;
            s_found = found;
            s_hc    = half_count;
        end
    endtask

    task automatic ramp(input int from, input int to, input logic st,
                        input int pk_sw, input int pk_det, input int base);
        int step;
        step = (to >= from) ? 1 : -1;
        for (int sw = from; sw != to + step; sw += step)
            drive(sw, st, (sw == pk_sw) ? pk_det : base);
    endtask

    initial begin
        rst         = 1'b1;
        on          = 1'b0;
        sweep_state = 1'b1;
        sweep_in    = '0;
        det_in      = '0;
        threshold   = 16'sd500;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_peak_val", peak_val, 0);
        chk("rst_peak_pos", peak_pos, 0);
        chk("rst_peak_dir", peak_dir, 0);
        chk("rst_peak_hit", peak_hit, 0);
        chk("rst_peak_valid", peak_valid, 0);
        chk("rst_found", found, 0);
        chk("rst_half_count", half_count, 0);

        // Idle with a direction change on the inputs, then arm inside a partial down-half
        rst = 1'b0;
        ramp(-93, -95, 1'b1, 999, 0, 0);
        chk("idle_no_report", pv_count, 0);
        on = 1'b1;
        ramp(-96, -99, 1'b1, 999, 0, 0);

        // Threshold hit: full up ramp, peak 1000 at 37
        ramp(-100, 100, 1'b0, 37, 1000, 0);
        chk("partial_not_reported", pv_count, 0);
        drive(99, 1'b1, 0);
        chk("latency_e0_quiet", peak_valid, 0);
        drive(98, 1'b1, 0);
        chk("hit_valid", peak_valid, 1);
        chk("hit_val", peak_val, 1000);
        chk("hit_pos", peak_pos, 37);
        chk("hit_dir", peak_dir, 0);
        chk("hit_hit", peak_hit, 1);
        chk("hit_half_count", half_count, 1);
        chk("hit_found_first", found, 0);
        drive(97, 1'b1, 0);
        chk("valid_not_stretched", peak_valid, 0);

        // Confirm: second hit on the down-half raises found
        ramp(96, -99, 1'b1, -20, 800, 0);
        ramp(-100, -90, 1'b0, 999, 0, 0);
        chk("conf_reports", pv_count, 2);
        chk("conf_val", s_val, 800);
        chk("conf_pos", s_pos, -20);
        chk("conf_dir", s_dir, 1);
        chk("conf_hit", s_hit, 1);
        chk("conf_half_count", s_hc, 2);
        chk("conf_found_rise", s_found, 1);

        // Third half peaks at only 100: miss clears found
        ramp(-89, 100, 1'b0, 0, 100, 0);
        drive(99, 1'b1, 0);
        drive(98, 1'b1, 0);
        chk("miss_valid", peak_valid, 1);
        chk("miss_val", peak_val, 100);
        chk("miss_pos", peak_pos, 0);
        chk("miss_hit", peak_hit, 0);
        chk("miss_found_fall", found, 0);
        chk("miss_half_count", half_count, 3);

        // Tie: 500 at sweep 10 and 20, earliest wins
        ramp(97, -100, 1'b1, 999, 0, 0);
        for (int sw = -99; sw <= 30; sw++)
            drive(sw, 1'b0, (sw == 10 || sw == 20) ? 500 : 0);
        drive(29, 1'b1, 0);
        drive(28, 1'b1, 0);
        chk("tie_valid", peak_valid, 1);
        chk("tie_pos", peak_pos, 10);
        chk("tie_val", peak_val, 500);
        chk("tie_hit", peak_hit, 1);
        chk("tie_half_count", half_count, 5);
        chk("tie_reports", pv_count, 5);
        chk("tie_found", found, 0);

        // Consecutive reversals: one-sample half-sweep at sweep 26
        drive(27, 1'b1, 0);
        drive(26, 1'b0, 300);
        drive(25, 1'b1, -5);
        chk("b2b_first_valid", peak_valid, 1);
        chk("b2b_first_pos", peak_pos, 29);
        chk("b2b_first_dir", peak_dir, 1);
        chk("b2b_first_hc", half_count, 6);
        drive(24, 1'b1, -5);
        chk("b2b_second_valid", peak_valid, 1);
        chk("b2b_second_val", peak_val, 300);
        chk("b2b_second_pos", peak_pos, 26);
        chk("b2b_second_dir", peak_dir, 0);
        chk("b2b_second_hc", half_count, 7);
        drive(23, 1'b1, 0);
        chk("b2b_then_quiet", peak_valid, 0);

        // Build found=1, then drop on mid-half
        threshold = 16'sd0;
        ramp(22, 20, 1'b1, 999, 0, 0);
        ramp(21, 25, 1'b0, 999, 0, 0);
        ramp(24, 22, 1'b1, 999, 0, 0);
        chk("pre_abort_found", found, 1);
        chk("pre_abort_hc", half_count, 9);
        chk("pre_abort_pos", peak_pos, 21);
        on = 1'b0;
        drive(21, 1'b1, 0);
        chk("abort_found", found, 0);
        chk("abort_half_count", half_count, 0);
        chk("abort_valid", peak_valid, 0);
        chk("abort_keep_pos", peak_pos, 21);
        chk("abort_keep_hit", peak_hit, 1);
        chk("abort_keep_dir", peak_dir, 0);
        drive(20, 1'b0, 0);
        ramp(19, 18, 1'b0, 999, 0, 0);
        chk("abort_no_report", pv_count, 9);

        // Re-enable, enter TRACK, then assert reset asynchronously
        on = 1'b1;
        ramp(17, 15, 1'b0, 999, 0, 0);
        ramp(14, 10, 1'b1, 999, 0, 0);
        rst = 1'b1;
        #2;
        chk("async_rst_pos", peak_pos, 0);
        chk("async_rst_hit", peak_hit, 0);
        chk("async_rst_val", peak_val, 0);
        chk("async_rst_valid", peak_valid, 0);
        chk("async_rst_found", found, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // ARM must ignore this large detector value until the first reversal
        ramp(-70, -61, 1'b0, 999, 0, 5000);
        chk("arm_no_report", pv_count, 9);
        chk("arm_half_count", half_count, 0);

        // Negative signals on a down-half, max -1500 at -50
        threshold = -16'sd1600;
        for (int sw = -40; sw >= -60; sw--)
            drive(sw, 1'b1, -1500 - 20 * ((sw + 50 < 0) ? -(sw + 50) : (sw + 50)));
        chk("neg_no_report_yet", pv_count, 9);
        drive(-59, 1'b0, -2000);
        drive(-58, 1'b0, -2000);
        chk("neg_valid", peak_valid, 1);
        chk("neg_val", peak_val, -1500);
        chk("neg_pos", peak_pos, -50);
        chk("neg_dir", peak_dir, 1);
        chk("neg_hit", peak_hit, 1);
        chk("neg_half_count", half_count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
